fifo_word_packer: RTL and testbench
===================================

FIFO_WORD_PACKER -- requirements
Module: fifo_word_packer

Interface
REQ-001 SHALL have parameter W, default 8, meaning byte (FIFO entry) width in bits.
REQ-002 SHALL have parameter N, default 4, meaning bytes per output word (N >= 2).
REQ-003 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port empty  input  1  upstream sync FIFO empty flag.
REQ-006 SHALL have port data_out  input  W  upstream FIFO head entry, valid whenever empty=0 (first-word-fall-through).
REQ-007 SHALL have port ren  output  1  pop request to upstream FIFO.
REQ-008 SHALL have port flush  input  1  single-cycle request to close the current partial word.
REQ-009 SHALL have port m_valid  output  1  packed word valid.
REQ-010 SHALL have port m_ready  input  1  downstream accept.
REQ-011 SHALL have port m_data  output  N*W  packed word.
REQ-012 SHALL have port m_keep  output  N  per-byte valid mask.
REQ-013 SHALL have port m_last  output  1  word closed by flush.

Function
REQ-014 SHALL hold an accumulator of N-1 bytes plus count acc_cnt (0..N-1) and a separate output register (m_data/m_keep/m_last/m_valid).
REQ-015 SHALL define out_free = !m_valid | m_ready (output register empty or being drained this cycle).
REQ-016 SHALL have states ACCUM and FLUSH; reset state ACCUM.
REQ-017 In ACCUM SHALL assert ren = !empty & !(acc_cnt==N-1 & !out_free); ren SHALL be combinational and never 1 while empty=1.
REQ-018 On a pop with acc_cnt<N-1 SHALL store data_out into byte lane acc_cnt and increment acc_cnt.
REQ-019 On a pop with acc_cnt==N-1 SHALL load output register same edge: lanes 0..N-2 from accumulator, lane N-1 from data_out, m_keep all ones, m_last=0, m_valid=1; acc_cnt -> 0 (one-byte-per-cycle sustained throughput).
REQ-020 Byte order SHALL be first-popped byte in m_data[W-1:0], increasing lanes thereafter.
REQ-021 m_valid SHALL deassert on m_valid&m_ready unless reloaded same edge; m_data/m_keep/m_last SHALL be stable while m_valid&!m_ready.
REQ-022 flush=1 in ACCUM SHALL move to FLUSH next edge; a pop in the same cycle SHALL be performed and included in the flushed word.
REQ-023 In FLUSH SHALL hold ren=0.
REQ-024 In FLUSH with acc_cnt==0 SHALL return to ACCUM next edge with no output.
REQ-025 In FLUSH with acc_cnt>0 and out_free SHALL load output: lanes <acc_cnt from accumulator, upper lanes zero, m_keep low acc_cnt bits set, m_last=1, m_valid=1; acc_cnt -> 0; return to ACCUM.
REQ-026 In FLUSH with acc_cnt>0 and !out_free SHALL wait in FLUSH.
REQ-027 If a flush pop completes a full word (REQ-019) SHALL emit it with m_last=1 and m_keep all ones, then FLUSH exits via REQ-024.
REQ-028 flush asserted while in FLUSH SHALL be ignored.

Reset
REQ-029 rst_n=0 SHALL asynchronously clear ren, m_valid, m_last, m_keep, m_data to 0, acc_cnt to 0, state to ACCUM; partial words SHALL be discarded.
REQ-030 First pop after reset SHALL occur no earlier than the first rising edge with rst_n=1.

Verification
REQ-031 Bytes 0x11,0x22,0x33,0x44 available, m_ready=1 -> ren high 4 cycles, m_data=0x44332211, m_keep=0xF, m_last=0, m_valid one cycle after 4th pop.
REQ-032 8 bytes 0x01..0x08 continuously, m_ready=0 until second word ready -> ren drops at acc_cnt==3, first word 0x04030201 held stable; after m_ready=1 second word 0x08070605 with no byte lost or duplicated.
REQ-033 Bytes 0xAA,0xBB then flush -> m_data=0x0000BBAA, m_keep=0x3, m_last=1; ren=0 during FLUSH.
REQ-034 flush with acc_cnt==0 -> no m_valid, back to ACCUM after one cycle.
REQ-035 rst_n pulsed low with acc_cnt==2 and m_valid=1 -> all outputs 0 immediately; next 4 bytes form a fresh word.
REQ-036 Random empty/m_ready/flush for 10000 cycles -> scoreboard: output byte stream (by m_keep) equals popped stream, m_last exactly once per non-empty flush.

Source files
------------

// File: rtl/fifo_word_packer.sv
// Packs W-bit entries from a first-word-fall-through FIFO into N-entry words with
// a per-byte keep mask. A flush closes the current partial word and marks it last.
module fwp_lane #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         we,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  q <= '0;
    else if (we) q <= d;
  end
endmodule

module fifo_word_packer #(
  parameter int W = 8,
  parameter int N = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           empty,
  input  logic [W-1:0]   data_out,
  output logic           ren,
  input  logic           flush,
  output logic           m_valid,
  input  logic           m_ready,
  output logic [N*W-1:0] m_data,
  output logic [N-1:0]   m_keep,
  output logic           m_last
);
  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] LAST = CW'(N-1);

  typedef enum logic {ACCUM, FLUSH} state_t;

  state_t                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [N-2:0][W-1:0]     acc_q;
  logic [N-2:0]            lane_we;
  logic                    mv_q, mv_d, ml_q, ml_d;
  logic [N*W-1:0]          md_q, md_d;
  logic [N-1:0]            mk_q, mk_d;
  logic                    out_free, full;

  for (genvar g = 0; g < N-1; g++) begin : g_lane
    fwp_lane #(.W(W)) u_lane (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (lane_we[g]),
      .d     (data_out),
      .q     (acc_q[g])
    );
  end

  always_comb begin
    out_free = !mv_q | m_ready;
    full     = (cnt_q == LAST);
    state_d  = state_q;
    cnt_d    = cnt_q;
    mv_d     = mv_q & !m_ready;
    md_d     = md_q;
    mk_d     = mk_q;
    ml_d     = ml_q;
    lane_we  = '0;
    ren      = 1'b0;
    case (state_q)
      ACCUM: begin
        // rst_n gating keeps ren low while reset is held, since ren is combinational
        ren = rst_n & !empty & !(full & !out_free);
        if (ren) begin
          if (full) begin
            for (int i = 0; i < N-1; i++) md_d[i*W +: W] = acc_q[i];
            md_d[(N-1)*W +: W] = data_out;
            mk_d  = '1;
            ml_d  = flush;
            mv_d  = 1'b1;
            cnt_d = '0;
          end else begin
            for (int i = 0; i < N-1; i++) lane_we[i] = (cnt_q == CW'(i));
            cnt_d = cnt_q + CW'(1);
          end
        end
        if (flush) state_d = FLUSH;
      end
      FLUSH: begin
        if (cnt_q == '0) begin
          state_d = ACCUM;
        end else if (out_free) begin
          md_d = '0;
          mk_d = '0;
          for (int i = 0; i < N-1; i++) begin
            if (CW'(i) < cnt_q) begin
              md_d[i*W +: W] = acc_q[i];
              mk_d[i]        = 1'b1;
            end
          end
          ml_d    = 1'b1;
          mv_d    = 1'b1;
          cnt_d   = '0;
          state_d = ACCUM;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ACCUM;
      cnt_q   <= '0;
      mv_q    <= 1'b0;
      md_q    <= '0;
      mk_q    <= '0;
      ml_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mv_q    <= mv_d;
      md_q    <= md_d;
      mk_q    <= mk_d;
      ml_q    <= ml_d;
    end
  end

  assign m_valid = mv_q;
  assign m_data  = md_q;
  assign m_keep  = mk_q;
  assign m_last  = ml_q;
endmodule

// File: tb/tb_fifo_word_packer.sv
// Bench for fifo_word_packer: directed vector table, hand sequences for backpressure
// and reset, then a randomized run against a byte-queue reference model.
module tb_fifo_word_packer;
  localparam int W = 8;
  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst_n, empty, ren, flush, m_valid, m_ready, m_last;
  logic [W-1:0]   data_out;
  logic [N*W-1:0] m_data;
  logic [N-1:0]   m_keep;

  int checks = 0;
  int errors = 0;

  fifo_word_packer #(.W(W), .N(N)) dut (
    .clk(clk), .rst_n(rst_n), .empty(empty), .data_out(data_out), .ren(ren),
    .flush(flush), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_keep(m_keep), .m_last(m_last)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic e; logic [7:0] d; logic f; logic r;
    logic x_ren; logic x_mv; logic [31:0] x_data; logic [3:0] x_keep; logic x_last;
  } vec_t;

  typedef struct {
    logic [N*W-1:0] data; logic [N-1:0] keep; logic last;
  } word_t;

  vec_t vt[23];

  // reference model state
  logic [7:0] cur[$];
  word_t      m_word;
  bit         m_full, m_flush;
  logic [7:0] head;
  int         nflush, lasts_seen;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic set_in(input logic e, input logic [7:0] d, input logic f, input logic r);
    @(negedge clk);
    empty = e; data_out = d; flush = f; m_ready = r;
    #1;
  endtask

  function automatic word_t mk_word(input logic [7:0] q[$], input logic last);
    word_t w;
    w.data = '0; w.keep = '0; w.last = last;
    for (int i = 0; i < q.size(); i++) begin
      w.data[i*W +: W] = q[i];
      w.keep[i]        = 1'b1;
    end
    return w;
  endfunction

  task automatic step_model(input logic e, input logic f, input logic r);
    bit exp_ren, out_free;
    set_in(e, head, f, r);
    out_free = !m_full || r;
    exp_ren  = !m_flush && !e && !(cur.size() == N-1 && !out_free);
    chk("rnd_ren", ren, exp_ren);
    chk("rnd_m_valid", m_valid, m_full);
    if (m_full) begin
      chk("rnd_m_data", m_data, m_word.data);
      chk("rnd_m_keep", m_keep, m_word.keep);
      chk("rnd_m_last", m_last, m_word.last);
    end
    if (m_full && r) begin
      if (m_word.last) lasts_seen++;
      m_full = 0;
    end
    if (m_flush) begin
      if (cur.size() == 0) m_flush = 0;
      else if (out_free) begin
        m_word = mk_word(cur, 1'b1); m_full = 1; cur.delete(); m_flush = 0;
      end
    end else begin
      bit done = 0;
      if (exp_ren) begin
        cur.push_back(head);
        head = 8'($urandom);
        if (cur.size() == N) begin
          m_word = mk_word(cur, f); m_full = 1; cur.delete(); done = 1;
        end
      end
      if (f) begin
        m_flush = 1;
        if (done || cur.size() > 0) nflush++;
      end
    end
  endtask

  initial begin
    int idx;
    vt[0]  = '{0, 8'h11, 0, 1, 1, 0, 0, 0, 0};
    vt[1]  = '{0, 8'h22, 0, 1, 1, 0, 0, 0, 0};
    vt[2]  = '{0, 8'h33, 0, 1, 1, 0, 0, 0, 0};
    vt[3]  = '{0, 8'h44, 0, 1, 1, 0, 0, 0, 0};
    vt[4]  = '{1, 8'h00, 0, 1, 0, 1, 32'h44332211, 4'hF, 0};
    vt[5]  = '{1, 8'h00, 0, 1, 0, 0, 0, 0, 0};
    vt[6]  = '{0, 8'hAA, 0, 1, 1, 0, 0, 0, 0};
    vt[7]  = '{0, 8'hBB, 0, 1, 1, 0, 0, 0, 0};
    vt[8]  = '{1, 8'h00, 1, 1, 0, 0, 0, 0, 0};
    vt[9]  = '{0, 8'hCC, 0, 1, 0, 0, 0, 0, 0};
    vt[10] = '{1, 8'h00, 0, 1, 0, 1, 32'h0000BBAA, 4'h3, 1};
    vt[11] = '{1, 8'h00, 0, 1, 0, 0, 0, 0, 0};
    vt[12] = '{1, 8'h00, 1, 1, 0, 0, 0, 0, 0};
    vt[13] = '{1, 8'h00, 0, 1, 0, 0, 0, 0, 0};
    vt[14] = '{0, 8'h55, 0, 1, 1, 0, 0, 0, 0};
    vt[15] = '{1, 8'h00, 1, 1, 0, 0, 0, 0, 0};
    vt[16] = '{0, 8'h66, 1, 1, 0, 0, 0, 0, 0};
    vt[17] = '{1, 8'h00, 0, 1, 0, 1, 32'h00000055, 4'h1, 1};
    vt[18] = '{0, 8'h77, 0, 1, 1, 0, 0, 0, 0};
    vt[19] = '{1, 8'h00, 1, 1, 0, 0, 0, 0, 0};
    vt[20] = '{1, 8'h00, 0, 1, 0, 0, 0, 0, 0};
    vt[21] = '{1, 8'h00, 0, 1, 0, 1, 32'h00000077, 4'h1, 1};
    vt[22] = '{1, 8'h00, 0, 1, 0, 0, 0, 0, 0};

    rst_n = 1'b0; empty = 1'b0; data_out = 8'h99; flush = 1'b0; m_ready = 1'b1;
    #12;
    chk("rst_ren", ren, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_m_keep", m_keep, 0);
    chk("rst_m_last", m_last, 0);
    @(negedge clk); empty = 1'b1; rst_n = 1'b1;

    for (int i = 0; i < 23; i++) begin
      set_in(vt[i].e, vt[i].d, vt[i].f, vt[i].r);
      chk($sformatf("vec%0d_ren", i), ren, vt[i].x_ren);
      chk($sformatf("vec%0d_m_valid", i), m_valid, vt[i].x_mv);
      if (vt[i].x_mv) begin
        chk($sformatf("vec%0d_m_data", i), m_data, vt[i].x_data);
        chk($sformatf("vec%0d_m_keep", i), m_keep, vt[i].x_keep);
        chk($sformatf("vec%0d_m_last", i), m_last, vt[i].x_last);
      end
    end

    // backpressure: 8 bytes, downstream stalled until second word is ready
    idx = 0;
    for (int c = 0; c < 8; c++) begin
      set_in(idx >= 8, 8'(idx + 1), 0, 0);
      if (ren) idx++;
    end
    chk("bp_ren_stall", ren, 0);
    chk("bp_popped", idx, 7);
    chk("bp_w1_data", m_data, 32'h04030201);
    for (int c = 0; c < 2; c++) begin
      set_in(0, 8'h08, 0, 0);
      chk("bp_hold_ren", ren, 0);
      chk("bp_hold_valid", m_valid, 1);
      chk("bp_hold_data", m_data, 32'h04030201);
    end
    set_in(0, 8'h08, 0, 1);
    chk("bp_ren_resume", ren, 1);
    chk("bp_w1_drain", m_data, 32'h04030201);
    set_in(1, 8'h00, 0, 1);
    chk("bp_w2_valid", m_valid, 1);
    chk("bp_w2_data", m_data, 32'h08070605);
    chk("bp_w2_keep", m_keep, 4'hF);
    set_in(1, 8'h00, 0, 1);
    chk("bp_w2_gone", m_valid, 0);

    // reset in the middle: partial word of 2 plus a held output word
    for (int i = 0; i < 6; i++) set_in(0, 8'(8'hB0 + i), 0, 0);
    @(negedge clk);
    chk("mid_pre_valid", m_valid, 1);
    rst_n = 1'b0; empty = 1'b0; #1;
    chk("mid_rst_ren", ren, 0);
    chk("mid_rst_valid", m_valid, 0);
    chk("mid_rst_data", m_data, 0);
    chk("mid_rst_keep", m_keep, 0);
    chk("mid_rst_last", m_last, 0);
    @(negedge clk); rst_n = 1'b1; data_out = 8'hA1; m_ready = 1'b1; #1;
    chk("mid_rel_ren", ren, 1);
    set_in(0, 8'hA2, 0, 1);
    set_in(0, 8'hA3, 0, 1);
    set_in(0, 8'hA4, 0, 1);
    set_in(1, 8'h00, 0, 1);
    chk("mid_fresh_valid", m_valid, 1);
    chk("mid_fresh_data", m_data, 32'hA4A3A2A1);
    chk("mid_fresh_keep", m_keep, 4'hF);

    // randomized run against the reference model, from a clean reset
    @(negedge clk); rst_n = 1'b0; empty = 1'b1;
    @(negedge clk); rst_n = 1'b1;
    cur.delete(); m_full = 0; m_flush = 0; nflush = 0; lasts_seen = 0;
    m_word = '{default: '0};
    head = 8'($urandom);
    for (int c = 0; c < 10000; c++)
      step_model(($urandom % 10) < 3, ($urandom % 20) == 0, ($urandom % 10) < 7);
    step_model(1, 1, 1);
    for (int c = 0; c < 8; c++) step_model(1, 0, 1);
    chk("rnd_drained", cur.size() + m_full, 0);
    chk("rnd_last_count", lasts_seen, nflush);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
